// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: control levels, register
// addresses and the controller's FSM states.
package definitions;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    typedef logic [4:0] RegAddr;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } HazState;

    // Writes to the hard-wired zero register never create a dependency.
    localparam RegAddr ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Load-use hazard detect: the FD instruction reads the register a load in EX writes.
// Purely combinational; zero latency, no flow control.
module load_use_detect
    import definitions::*;
(
    input  RegAddr fd_rs1,
    input  RegAddr fd_rs2,
    input  Signal  fd_uses_rs1,
    input  Signal  fd_uses_rs2,
    input  RegAddr dx_rd,
    input  Signal  dx_reg_write,
    input  Signal  dx_mem_read,
    output logic   lu
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = (fd_uses_rs1 == ENABLE) && (fd_rs1 == dx_rd);
        rs2_hit = (fd_uses_rs2 == ENABLE) && (fd_rs2 == dx_rd);
        lu      = (dx_mem_read == ENABLE) && (dx_reg_write == ENABLE) &&
                  (dx_rd != ZERO_REG) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for FD/DX: stalls on load-use and multi-cycle ops, flushes on taken branch.
// Control outputs are combinational (zero latency); stall_count is a saturating registered count.
module hazard_ctrl
    import definitions::*;
#(
    parameter int MUL_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  RegAddr                 fd_rs1,
    input  RegAddr                 fd_rs2,
    input  Signal                  fd_uses_rs1,
    input  Signal                  fd_uses_rs2,
    input  RegAddr                 dx_rd,
    input  Signal                  dx_reg_write,
    input  Signal                  dx_mem_read,
    input  Signal                  dx_multi,
    input  Signal                  branch_taken,
    output Signal                  pc_stall,
    output Signal                  fd_stall,
    output Signal                  fd_flush,
    output Signal                  dx_bubble,
    output Signal                  dx_stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // The RUN cycle that detects the event is the first of the sequence, so
    // the counter only covers the remaining cycles after the first FSM cycle.
    localparam int MUL_LOAD = (MUL_LATENCY > 3) ? MUL_LATENCY - 3 : 0;
    localparam int FL_LOAD  = (FLUSH_CYCLES > 2) ? FLUSH_CYCLES - 2 : 0;
    localparam int CNT_MAX  = (MUL_LOAD > FL_LOAD) ? MUL_LOAD : FL_LOAD;
    localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    HazState                  state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0]   stall_count_q, stall_count_d;
    logic                     lu;

    load_use_detect u_load_use_detect (
        .fd_rs1       (fd_rs1),
        .fd_rs2       (fd_rs2),
        .fd_uses_rs1  (fd_uses_rs1),
        .fd_uses_rs2  (fd_uses_rs2),
        .dx_rd        (dx_rd),
        .dx_reg_write (dx_reg_write),
        .dx_mem_read  (dx_mem_read),
        .lu           (lu)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_stall  = DISABLE;
        fd_stall  = DISABLE;
        fd_flush  = DISABLE;
        dx_bubble = DISABLE;
        dx_stall  = DISABLE;

        unique case (state_q)
            RUN: begin
                if (branch_taken == ENABLE) begin
                    fd_flush  = ENABLE;
                    dx_bubble = ENABLE;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = CNT_W'(FL_LOAD);
                        state_d = FLUSH;
                    end
                end else if ((dx_multi == ENABLE) && (MUL_LATENCY > 1)) begin
                    pc_stall = ENABLE;
                    fd_stall = ENABLE;
                    dx_stall = ENABLE;
                    if (MUL_LATENCY > 2) begin
                        cnt_d   = CNT_W'(MUL_LOAD);
                        state_d = MULTI;
                    end
                end else if (lu) begin
                    pc_stall  = ENABLE;
                    fd_stall  = ENABLE;
                    dx_bubble = ENABLE;
                end
            end
            MULTI: begin
                pc_stall = ENABLE;
                fd_stall = ENABLE;
                dx_stall = ENABLE;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FLUSH: begin
                fd_flush = ENABLE;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = RUN;
        endcase

        // Outputs read as idle for the whole reset cycle, even mid-sequence.
        if (rst) begin
            pc_stall  = DISABLE;
            fd_stall  = DISABLE;
            fd_flush  = DISABLE;
            dx_bubble = DISABLE;
            dx_stall  = DISABLE;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if ((pc_stall == ENABLE) && (stall_count_q != '1))
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = rst ? '0 : stall_count_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the fetch/decode (FD) and decode/execute (DX) pipeline registers. Each cycle it decides whether the PC and FD hold (stall), whether a NOP bubble enters DX, and whether wrong-path instructions are flushed from FD. It handles load-use hazards, multi-cycle execute operations and taken-branch redirects. It also keeps a saturating count of stall cycles. It sits beside the decode stage, driving the `stall` input of FD, the NOP-injection mux on FD's `instr_i`, and the DX register controls.

## Interface
Parameters:
- MUL_LATENCY, 4: cycles a multi-cycle op occupies EX; legal range is ≥1.
- FLUSH_CYCLES, 2: consecutive cycles fd_flush is held after a taken branch; legal range is ≥1.
- STALL_CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- fd_rs1, fd_rs2  in  RegAddr  source registers of the instruction at the FD output.
- fd_uses_rs1, fd_uses_rs2  in  Signal  ENABLE when the corresponding source register is actually read.
- dx_rd  in  RegAddr  destination register of the instruction in EX.
- dx_reg_write  in  Signal  instruction in EX writes dx_rd.
- dx_mem_read  in  Signal  instruction in EX is a load.
- dx_multi  in  Signal  instruction in EX is a multi-cycle op.
- branch_taken  in  Signal  branch resolved taken in EX this cycle.
- pc_stall  out  Signal  hold the PC.
- fd_stall  out  Signal  drives FD `stall`.
- fd_flush  out  Signal  selects a NOP into FD `instr_i`.
- dx_bubble  out  Signal  load a NOP into DX.
- dx_stall  out  Signal  hold DX.
- stall_count  out  STALL_CNT_W  number of cycles with pc_stall=ENABLE.

## Operation
- FSM states are RUN, MULTI and FLUSH. A down-counter `cnt` is shared by MULTI and FLUSH.
- Outputs are combinational from the state and the inputs. Any output not named ENABLE in a case below is DISABLE.
- **Load-use hazard (`lu`):** dx_mem_read & dx_reg_write & (dx_rd≠0) & ((fd_uses_rs1 & fd_rs1==dx_rd) | (fd_uses_rs2 & fd_rs2==dx_rd)).

RUN, priority from highest to lowest:
1. branch_taken: fd_flush and dx_bubble are ENABLE. If FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-2 and go to FLUSH; otherwise stay in RUN.
2. dx_multi with MUL_LATENCY>1: pc_stall, fd_stall and dx_stall are ENABLE. If MUL_LATENCY>2, load cnt=MUL_LATENCY-3 and go to MULTI; otherwise stay in RUN.
3. lu: pc_stall, fd_stall and dx_bubble are ENABLE for this cycle only. Stay in RUN.
4. Otherwise all outputs are DISABLE.

MULTI:
- pc_stall, fd_stall and dx_stall are ENABLE.
- If cnt==0, go to RUN; else decrement cnt.
- branch_taken, lu and dx_multi are ignored.

FLUSH:
- fd_flush is ENABLE; all other control outputs are DISABLE.
- If cnt==0, go to RUN; else decrement cnt.
- All hazard inputs are ignored.

Stall behaviour:
- A multi-cycle op stalls upstream for exactly MUL_LATENCY-1 cycles in total.
- MUL_LATENCY=1 never stalls.

Outputs are mutually consistent:
- fd_flush is never asserted together with fd_stall.
- dx_bubble is never asserted together with dx_stall.

stall_count:
- Increments on every clock edge where pc_stall=ENABLE.
- Saturates at all-ones and never wraps.

## Timing
- Reset value of every output, held for the whole cycle in which rst=1: every Signal output is DISABLE and stall_count is 0.
- At the reset edge: state←RUN, cnt←0, stall_count←0.
- Reset mid-MULTI or mid-FLUSH aborts the sequence. The first cycle after reset is RUN with no residual stall.
- Control outputs have zero latency: a hazard is acted on in the same cycle its inputs appear.
- A state change is visible in the cycle after the edge.
- Simultaneous branch_taken and lu in RUN: the flush wins and no stall occurs.
- Simultaneous dx_multi and lu in RUN: the multi-cycle op wins. After it retires, lu is re-evaluated against the new EX contents.
- After the last MULTI cycle, the DX register advances at the next edge. dx_multi on the following RUN cycle refers to the next instruction.

## Structure
- Package `definitions` provides `Signal` (DISABLE/ENABLE) and `RegAddr`.
- Add to `definitions`:
  - enum `HazState` {RUN, MULTI, FLUSH}.
  - constant `ZERO_REG`, used in the dx_rd≠0 check.
- One combinational sub-module, `load_use_detect`, computes lu. The FSM, the counters and the output decode live in hazard_ctrl.

## Test plan
- **Load-use:** dx_mem_read=dx_reg_write=ENABLE, dx_rd=5, fd_rs2=5, fd_uses_rs2=ENABLE. Required: one cycle of pc_stall, fd_stall and dx_bubble; stall_count goes 0→1. The same stimulus with dx_rd=0 produces no stall.
- **Multi-cycle op:** MUL_LATENCY=4, dx_multi held ENABLE. Required: pc_stall, fd_stall and dx_stall for exactly 3 cycles (RUN→MULTI→MULTI→RUN); stall_count=3.
- **Taken branch:** FLUSH_CYCLES=2, branch_taken pulsed. Required: cycle 0 has fd_flush and dx_bubble; cycle 1 has fd_flush only; cycle 2 has all outputs DISABLE.
- **Priority:** branch_taken and lu together → flush only. dx_multi and lu together → 3-cycle multi stall and no dx_bubble.
- **Reset mid-MULTI:** rst asserted in the second MULTI cycle. Required: all outputs DISABLE that cycle, and RUN with zero stall_count afterwards.
- **Saturation:** STALL_CNT_W=4 and 20 stalled cycles → stall_count holds at 15.
